// File: rtl/data_mem_ctrl_if.sv
// Load/store request bus between the processor datapath and the data memory.
// The master drives requests with address and store data.
// The slave returns load data with completion, busy and error status.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              Ldr;
  logic              Str;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WdatM;
  logic [DATA_W-1:0] Rdat;
  logic              RdatValid;
  logic              Done;
  logic              Busy;
  logic              Err;

  modport master (
    output Ldr, Str, Addr, WdatM,
    input  Rdat, RdatValid, Done, Busy, Err
  );

  modport slave (
    input  Ldr, Str, Addr, WdatM,
    output Rdat, RdatValid, Done, Busy, Err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: services one load or store at a time against an internal array.
// Latency: request accepted in cycle N completes with a Done pulse in cycle N+LAT.
// Backpressure: Busy is high while a request is in flight; requests seen while Busy are dropped and flagged on Err.
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LAT    = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  data_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Counter holds the number of Busy cycles still to run; 4 bits cover LAT up to 15.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_ld_q, op_ld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rdat_vld_q, rdat_vld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Array is deliberately left out of reset so stored data survives a controller reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Access strobe for the edge that actually touches the array.
  logic              acc;
  logic              acc_ld;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdat;
  logic              mem_we;

  logic req_one;
  logic req_both;
  logic req_any;

  assign req_one  = bus.Ldr ^ bus.Str;
  assign req_both = bus.Ldr & bus.Str;
  assign req_any  = bus.Ldr | bus.Str;

  // Next-state, counter, latch and registered-output computation for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_ld_d    = op_ld_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    rdat_vld_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    acc        = 1'b0;
    acc_ld     = op_ld_q;
    acc_addr   = addr_q;
    acc_wdat   = wdat_q;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_one) begin
          op_ld_d = bus.Ldr;
          addr_d  = bus.Addr;
          wdat_d  = bus.WdatM;
          cnt_d   = CNT_INIT;
          if (LAT == 1) begin
            // Single-cycle latency: access straight from the request inputs, no WAIT state.
            acc      = 1'b1;
            acc_ld   = bus.Ldr;
            acc_addr = bus.Addr;
            acc_wdat = bus.WdatM;
          end else begin
            state_d = S_WAIT;
          end
        end else if (req_both) begin
          err_d = 1'b1;
        end
      end

      S_WAIT: begin
        // Anything arriving while Busy is dropped; the transfer in flight continues.
        if (req_any) begin
          err_d = 1'b1;
        end
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last Busy cycle: access at this edge, Done appears next cycle.
          cnt_d   = 4'd0;
          acc     = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc) begin
      done_d = 1'b1;
      if (acc_ld) begin
        rdat_d     = mem_q[acc_addr];
        rdat_vld_d = 1'b1;
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  // FSM state, counter, request latches and registered outputs; Reset aborts any transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_ld_q    <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      rdat_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_ld_q    <= op_ld_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      rdat_vld_q <= rdat_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Store write port; a store still pending when Reset arrives is never written.
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) begin
      mem_q[acc_addr] <= acc_wdat;
    end
  end

  assign bus.Rdat      = rdat_q;
  assign bus.RdatValid = rdat_vld_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;
  assign bus.Busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with LAT=3 and one with LAT=1.
// Stimulus pushes expected completions/errors into queues; monitors pop and compare.
// Directed checks cover reset state, Busy windows and reset abort.
module tb_data_mem_ctrl;

  typedef struct {
    int         cyc;
    bit         ld;
    logic [7:0] rdat;
  } exp_t;

  logic clk;
  logic rst3;
  logic rst1;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   busy_seen1;

  exp_t q3[$];
  exp_t q1[$];
  int   e3[$];
  int   e1[$];

  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if3 ();
  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) if1 ();

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .LAT(3)) dut3 (
    .Clk  (clk),
    .Reset(rst3),
    .bus  (if3.slave)
  );

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .LAT(1)) dut1 (
    .Clk  (clk),
    .Reset(rst1),
    .bus  (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the LAT=3 instance.
  always @(negedge clk) begin
    if (if3.Done) begin
      n_tests++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL done3_unexpected cyc=%0d got Done=1 required no Done", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (e.cyc != cyc || if3.RdatValid !== e.ld || (e.ld && if3.Rdat !== e.rdat)) begin
          n_fail++;
          $display("FAIL done3 got cyc=%0d vld=%0b rdat=%h required cyc=%0d vld=%0b rdat=%h",
                   cyc, if3.RdatValid, if3.Rdat, e.cyc, e.ld, e.rdat);
        end
      end
    end else if (if3.RdatValid) begin
      n_tests++;
      n_fail++;
      $display("FAIL vld3_without_done cyc=%0d got RdatValid=1 required 0", cyc);
    end
    if (if3.Err) begin
      n_tests++;
      if (e3.size() == 0) begin
        n_fail++;
        $display("FAIL err3_unexpected cyc=%0d got Err=1 required 0", cyc);
      end else begin
        int ec;
        ec = e3.pop_front();
        if (ec != cyc) begin
          n_fail++;
          $display("FAIL err3 got cyc=%0d required cyc=%0d", cyc, ec);
        end
      end
    end
  end

  // Monitor for the LAT=1 instance.
  always @(negedge clk) begin
    if (if1.Busy) busy_seen1 = 1'b1;
    if (if1.Done) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL done1_unexpected cyc=%0d got Done=1 required no Done", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.cyc != cyc || if1.RdatValid !== e.ld || (e.ld && if1.Rdat !== e.rdat)) begin
          n_fail++;
          $display("FAIL done1 got cyc=%0d vld=%0b rdat=%h required cyc=%0d vld=%0b rdat=%h",
                   cyc, if1.RdatValid, if1.Rdat, e.cyc, e.ld, e.rdat);
        end
      end
    end else if (if1.RdatValid) begin
      n_tests++;
      n_fail++;
      $display("FAIL vld1_without_done cyc=%0d got RdatValid=1 required 0", cyc);
    end
    if (if1.Err) begin
      n_tests++;
      if (e1.size() == 0) begin
        n_fail++;
        $display("FAIL err1_unexpected cyc=%0d got Err=1 required 0", cyc);
      end else begin
        int ec;
        ec = e1.pop_front();
        if (ec != cyc) begin
          n_fail++;
          $display("FAIL err1 got cyc=%0d required cyc=%0d", cyc, ec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Drive a one-cycle request on the LAT=3 instance; returns in the following cycle.
  task automatic req3(input logic l, input logic s, input logic [7:0] a, input logic [7:0] w);
    if3.Ldr   = l;
    if3.Str   = s;
    if3.Addr  = a;
    if3.WdatM = w;
    tick();
    if3.Ldr = 1'b0;
    if3.Str = 1'b0;
  endtask

  task automatic push3(input int c, input bit ld, input logic [7:0] d);
    exp_t e;
    e.cyc  = c;
    e.ld   = ld;
    e.rdat = d;
    q3.push_back(e);
  endtask

  task automatic push1(input int c, input bit ld, input logic [7:0] d);
    exp_t e;
    e.cyc  = c;
    e.ld   = ld;
    e.rdat = d;
    q1.push_back(e);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_tests    = 0;
    n_fail     = 0;
    busy_seen1 = 1'b0;
    if3.Ldr = 1'b0; if3.Str = 1'b0; if3.Addr = '0; if3.WdatM = '0;
    if1.Ldr = 1'b0; if1.Str = 1'b0; if1.Addr = '0; if1.WdatM = '0;
    rst3 = 1'b1;
    rst1 = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset3_outputs", 32'({if3.Rdat, if3.RdatValid, if3.Done, if3.Busy, if3.Err}), 32'h0);
    chk("reset1_outputs", 32'({if1.Rdat, if1.RdatValid, if1.Done, if1.Busy, if1.Err}), 32'h0);
    tick();
    rst3 = 1'b0;
    rst1 = 1'b0;
    tick();

    // LAT=3: store 0x10=A5, Busy in N+1..N+2, Done in N+3.
    n = cyc;
    push3(n + 3, 1'b0, 8'h00);
    req3(1'b0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk); chk("busy3_n1", 32'(if3.Busy), 32'h1);
    tick();
    @(negedge clk); chk("busy3_n2", 32'(if3.Busy), 32'h1);
    tick();
    @(negedge clk); chk("busy3_n3", 32'(if3.Busy), 32'h0);
    tick();

    // Load 0x10 returns A5 three cycles later.
    n = cyc;
    push3(n + 3, 1'b1, 8'hA5);
    req3(1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    tick();

    // In the load's Done cycle: store 0x20=3C, then load 0x20 in the store's Done cycle.
    n = cyc;
    push3(n + 3, 1'b0, 8'h00);
    req3(1'b0, 1'b1, 8'h20, 8'h3C);
    tick();
    tick();
    @(negedge clk); chk("rdat3_kept_over_store", 32'(if3.Rdat), 32'hA5);
    n = cyc;
    push3(n + 3, 1'b1, 8'h3C);
    req3(1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    tick();

    // Pre-store 0x05=5A and 0x30=11 for later checks.
    n = cyc;
    push3(n + 3, 1'b0, 8'h00);
    req3(1'b0, 1'b1, 8'h05, 8'h5A);
    tick();
    tick();
    n = cyc;
    push3(n + 3, 1'b0, 8'h00);
    req3(1'b0, 1'b1, 8'h30, 8'h11);
    tick();
    tick();
    tick();

    // Ldr and Str together while idle: Err next cycle, no Busy, no Done.
    n = cyc;
    e3.push_back(n + 1);
    req3(1'b1, 1'b1, 8'h05, 8'hEE);
    @(negedge clk); chk("busy3_after_both", 32'(if3.Busy), 32'h0);
    tick();
    tick();
    n = cyc;
    push3(n + 3, 1'b1, 8'h5A);
    req3(1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    tick();
    tick();

    // Load 0x10 in flight, store 0x10=FF while Busy is dropped with Err.
    n = cyc;
    push3(n + 3, 1'b1, 8'hA5);
    req3(1'b1, 1'b0, 8'h10, 8'h00);
    e3.push_back(n + 2);
    req3(1'b0, 1'b1, 8'h10, 8'hFF);
    tick();
    tick();
    n = cyc;
    push3(n + 3, 1'b1, 8'hA5);
    req3(1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    tick();
    tick();

    // Store 0x30=77 aborted by Reset in N+1: outputs cleared, no Done, no write.
    req3(1'b0, 1'b1, 8'h30, 8'h77);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    @(negedge clk);
    chk("abort3_outputs", 32'({if3.Rdat, if3.RdatValid, if3.Done, if3.Busy, if3.Err}), 32'h0);
    tick();
    tick();
    tick();
    tick();
    n = cyc;
    push3(n + 3, 1'b1, 8'h11);
    req3(1'b1, 1'b0, 8'h30, 8'h00);
    tick();
    tick();
    tick();

    // LAT=1: back-to-back stores of 1..4 to 0x00..0x03, then back-to-back loads.
    for (int k = 0; k < 4; k++) begin
      if1.Str   = 1'b1;
      if1.Addr  = 8'(k);
      if1.WdatM = 8'(k + 1);
      push1(cyc + 1, 1'b0, 8'h00);
      tick();
    end
    if1.Str = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if1.Ldr  = 1'b1;
      if1.Addr = 8'(k);
      push1(cyc + 1, 1'b1, 8'(k + 1));
      tick();
    end
    if1.Ldr = 1'b0;
    tick();
    @(negedge clk); chk("rdat1_holds_last", 32'(if1.Rdat), 32'h4);
    tick();

    // LAT=1: Ldr and Str together flag Err next cycle.
    if1.Ldr = 1'b1;
    if1.Str = 1'b1;
    e1.push_back(cyc + 1);
    tick();
    if1.Ldr = 1'b0;
    if1.Str = 1'b0;
    tick();
    tick();
    tick();

    chk("q3_drained", 32'(q3.size()), 32'h0);
    chk("e3_drained", 32'(e3.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("e1_drained", 32'(e1.size()), 32'h0);
    chk("busy1_never", 32'(busy_seen1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
